conv_window_scheduler: RTL and testbench



---
 rtl/conv_window_scheduler_if.sv | 33 +++
 rtl/conv_window_scheduler.sv | 144 ++++++++++++++
 tb/tb_conv_window_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_scheduler_if.sv
// Handshake bundle between the window scheduler and the config, SRAM fetch,
// register-array and OPU sides.
interface conv_window_scheduler_if #(
  parameter int CW   = 8,
  parameter int BITS = 8
);
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

  logic          start;
  logic [CW-1:0] pic_size;
  logic          padding;
  logic          busy;
  logic          done;
  logic          fetch_vld;
  logic          fetch_rdy;
  logic [CW-1:0] win_x;
  logic [CW-1:0] win_y;
  logic [BW-1:0] win_bit;
  logic          load_done;
  logic          opu_vld;
  logic          opu_rdy;
  logic          opu_last;

  modport master (
    input  start, pic_size, padding, fetch_rdy, load_done, opu_rdy,
    output busy, done, fetch_vld, win_x, win_y, win_bit, opu_vld, opu_last
  );

  modport slave (
    output start, pic_size, padding, fetch_rdy, load_done, opu_rdy,
    input  busy, done, fetch_vld, win_x, win_y, win_bit, opu_vld, opu_last
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Zig-zag 3x3 window scan over a square bit-serial picture: per window it walks
// every bit-plane through fetch -> register-array load -> OPU presentation.
module conv_window_scheduler #(
  parameter int CW   = 8,
  parameter int BITS = 8
) (
  input  logic sys_clk,
  input  logic sys_rst,
  conv_window_scheduler_if.master bus
);
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_LOAD, PRESENT, ADVANCE, FINISH} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] w_reg, w_next;
  logic          pad_reg, pad_next;
  logic [CW-1:0] x_reg, x_next;
  logic [CW-1:0] y_reg, y_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic [CW:0]   k_reg, k_next;
  logic [CW-1:0] line_reg, line_next;

  logic [CW+1:0] span;
  logic [CW-1:0] origin;
  logic [CW:0]   lines;
  logic [CW:0]   line_len;
  logic          last_line, single_col, last_in_line, last_bit;

  // Two-column lines hold 2W windows; an odd W leaves a single column at the end.
  assign span         = (CW+2)'(bus.pic_size) + (CW+2)'({bus.padding, 1'b0});
  assign origin       = {CW{pad_reg}};
  assign lines        = ({1'b0, w_reg} + (CW+1)'(1)) >> 1;
  assign last_line    = ({1'b0, line_reg} == lines - (CW+1)'(1));
  assign single_col   = w_reg[0] & last_line;
  assign line_len     = single_col ? {1'b0, w_reg} : {w_reg, 1'b0};
  assign last_in_line = (k_reg == line_len - (CW+1)'(1));
  assign last_bit     = (bit_reg == BW'(BITS - 1));

  assign bus.busy      = (state_reg != IDLE) && (state_reg != FINISH);
  assign bus.done      = (state_reg == FINISH);
  assign bus.fetch_vld = (state_reg == FETCH);
  assign bus.opu_vld   = (state_reg == PRESENT);
  assign bus.opu_last  = (state_reg == PRESENT) && last_bit && last_line && last_in_line;
  assign bus.win_x     = x_reg;
  assign bus.win_y     = y_reg;
  assign bus.win_bit   = bit_reg;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      w_reg     <= '0;
      pad_reg   <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      bit_reg   <= '0;
      k_reg     <= '0;
      line_reg  <= '0;
    end else begin
      state_reg <= state_next;
      w_reg     <= w_next;
      pad_reg   <= pad_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      bit_reg   <= bit_next;
      k_reg     <= k_next;
      line_reg  <= line_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    w_next     = w_reg;
    pad_next   = pad_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    bit_next   = bit_reg;
    k_next     = k_reg;
    line_next  = line_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          pad_next = bus.padding;
          w_next   = CW'(span - (CW+2)'(2));
          if (span < (CW+2)'(3)) begin
            state_next = FINISH;
          end else begin
            x_next     = {CW{bus.padding}};
            y_next     = {CW{bus.padding}};
            bit_next   = '0;
            k_next     = '0;
            line_next  = '0;
            state_next = FETCH;
          end
        end
      end
      FETCH: begin
        // A load_done arriving here belongs to no request and is dropped.
        if (bus.fetch_rdy) state_next = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (bus.load_done) state_next = PRESENT;
      end
      PRESENT: begin
        if (bus.opu_rdy) begin
          if (last_bit) begin
            state_next = ADVANCE;
          end else begin
            bit_next   = bit_reg + BW'(1);
            state_next = FETCH;
          end
        end
      end
      ADVANCE: begin
        bit_next = '0;
        if (last_in_line) begin
          if (last_line) begin
            state_next = FINISH;
          end else begin
            line_next  = line_reg + CW'(1);
            k_next     = '0;
            x_next     = origin + CW'({line_next, 1'b0});
            y_next     = origin;
            state_next = FETCH;
          end
        end else begin
          k_next = k_reg + (CW+1)'(1);
          if (single_col) begin
            y_next = y_reg + CW'(1);
          end else begin
            case (k_reg[1:0])
              2'd0:    x_next = x_reg + CW'(1);
              2'd2:    x_next = x_reg - CW'(1);
              default: y_next = y_reg + CW'(1);
            endcase
          end
          state_next = FETCH;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: drives the fetch/load/OPU handshakes,
// records the window scan and compares it with hand-derived scan orders.
module tb_conv_window_scheduler;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int checks = 0;
  int failures = 0;

  conv_window_scheduler_if #(.CW(8), .BITS(8)) bus ();

  conv_window_scheduler #(.CW(8), .BITS(8)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] wx [256];
  logic [7:0] wy [256];
  int nwin, fetches, hs, lasts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input int idx, input logic [7:0] ex, input logic [7:0] ey);
    chk($sformatf("win%0d_x", idx), 32'(wx[idx]), 32'(ex));
    chk($sformatf("win%0d_y", idx), 32'(wy[idx]), 32'(ey));
  endtask

  // Acts as SRAM path, register array and OPU with fixed response delays.
  task automatic run_scan(input int p, input int pad, input int fd, input int ld, input int od,
                          input bit spur, input bit restart, input int total);
    int cyc, fwait, owait, load_cnt, last_hs;
    bit load_pend, load_sent;
    logic [7:0] cur_x, cur_y;
    logic [2:0] cur_b;
    cyc = 0; fwait = 0; owait = 0; load_cnt = 0; last_hs = 0;
    load_pend = 0; load_sent = 0; cur_x = '0; cur_y = '0; cur_b = '0;
    nwin = 0; fetches = 0; hs = 0; lasts = 0;
    bus.start = 1'b1;
    bus.pic_size = 8'(p);
    bus.padding = pad[0];
    @(negedge sys_clk);
    cyc = 1;
    forever begin
      bus.start = 1'b0;
      bus.fetch_rdy = 1'b0;
      bus.load_done = 1'b0;
      bus.opu_rdy = 1'b0;
      if (cyc > 40000) begin
        chk("scan_timeout", 32'(cyc), 32'd40000);
        break;
      end
      if (bus.done === 1'b1) begin
        if (total == 0) chk("done_latency_start", 32'(cyc), 32'd1);
        else chk("done_latency_last_hs", 32'(cyc - last_hs), 32'd2);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        break;
      end
      chk("busy_during_scan", 32'(bus.busy), 32'd1);
      if (restart && cyc == 12) begin
        bus.start = 1'b1;
        bus.pic_size = 8'd2;
        bus.padding = ~pad[0];
      end
      if (bus.opu_vld !== 1'b1) chk("opu_last_without_vld", 32'(bus.opu_last), 32'd0);
      if (bus.opu_vld === 1'b1) chk("load_before_opu", 32'(load_sent), 32'd1);
      if (bus.fetch_vld === 1'b1) begin
        if (fwait == 0) begin
          cur_x = bus.win_x; cur_y = bus.win_y; cur_b = bus.win_bit;
          chk("fetch_win_bit", 32'(bus.win_bit), 32'(fetches % 8));
          if (fetches % 8 == 0) begin
            wx[nwin] = bus.win_x; wy[nwin] = bus.win_y; nwin++;
          end else begin
            chk("plane_x_same_window", 32'(cur_x), 32'(wx[nwin-1]));
            chk("plane_y_same_window", 32'(cur_y), 32'(wy[nwin-1]));
          end
        end else begin
          chk("fetch_x_stable", 32'(bus.win_x), 32'(cur_x));
          chk("fetch_y_stable", 32'(bus.win_y), 32'(cur_y));
          chk("fetch_bit_stable", 32'(bus.win_bit), 32'(cur_b));
        end
        if (fwait >= fd) begin
          bus.fetch_rdy = 1'b1;
          fetches++; fwait = 0;
          load_pend = 1; load_cnt = ld; load_sent = 0;
          if (spur) bus.load_done = 1'b1;
        end else begin
          fwait++;
        end
      end else if (load_pend) begin
        if (load_cnt == 0) begin
          bus.load_done = 1'b1; load_pend = 0; load_sent = 1;
        end else begin
          load_cnt--;
        end
      end else if (bus.opu_vld === 1'b1) begin
        chk("opu_x_stable", 32'(bus.win_x), 32'(cur_x));
        chk("opu_y_stable", 32'(bus.win_y), 32'(cur_y));
        chk("opu_bit_stable", 32'(bus.win_bit), 32'(cur_b));
        if (owait >= od) begin
          bus.opu_rdy = 1'b1;
          chk("opu_last", 32'(bus.opu_last), 32'(hs == total - 1));
          if (bus.opu_last === 1'b1) lasts++;
          hs++; owait = 0; last_hs = cyc; load_sent = 0;
        end else begin
          owait++;
        end
      end
      @(negedge sys_clk);
      cyc++;
    end
    bus.start = 1'b0; bus.fetch_rdy = 1'b0; bus.load_done = 1'b0; bus.opu_rdy = 1'b0;
    chk("fetch_count", 32'(fetches), 32'(total));
    chk("opu_hs_count", 32'(hs), 32'(total));
    chk("window_count", 32'(nwin), 32'(total / 8));
    chk("opu_last_count", 32'(lasts), 32'(total > 0));
    @(negedge sys_clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.pic_size = '0; bus.padding = 1'b0;
    bus.fetch_rdy = 1'b0; bus.load_done = 1'b0; bus.opu_rdy = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_fetch_vld", 32'(bus.fetch_vld), 32'd0);
    chk("rst_opu_vld", 32'(bus.opu_vld), 32'd0);
    chk("rst_opu_last", 32'(bus.opu_last), 32'd0);
    chk("rst_win_x", 32'(bus.win_x), 32'd0);
    chk("rst_win_y", 32'(bus.win_y), 32'd0);
    chk("rst_win_bit", 32'(bus.win_bit), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // P=4, no padding: one paired line of 4 windows
    run_scan(4, 0, 0, 0, 0, 1'b0, 1'b0, 32);
    chk_win(0, 8'h00, 8'h00);
    chk_win(1, 8'h01, 8'h00);
    chk_win(2, 8'h01, 8'h01);
    chk_win(3, 8'h00, 8'h01);
    $display("scan P=4 pad=0: windows=%0d handshakes=%0d", nwin, hs);

    // P=8 with padding: 4 paired lines of 16 windows
    run_scan(8, 1, 0, 0, 0, 1'b0, 1'b0, 512);
    chk_win(0, 8'hFF, 8'hFF);
    chk_win(1, 8'h00, 8'hFF);
    chk_win(2, 8'h00, 8'h00);
    chk_win(3, 8'hFF, 8'h00);
    chk_win(15, 8'hFF, 8'h06);
    chk_win(16, 8'h01, 8'hFF);
    chk_win(48, 8'h05, 8'hFF);
    chk_win(63, 8'h05, 8'h06);
    $display("scan P=8 pad=1: windows=%0d handshakes=%0d", nwin, hs);

    // P=5: odd W leaves a single trailing column; spurious load_done on fetch accept
    run_scan(5, 0, 0, 1, 0, 1'b1, 1'b0, 72);
    chk_win(0, 8'h00, 8'h00);
    chk_win(1, 8'h01, 8'h00);
    chk_win(2, 8'h01, 8'h01);
    chk_win(3, 8'h00, 8'h01);
    chk_win(4, 8'h00, 8'h02);
    chk_win(5, 8'h01, 8'h02);
    chk_win(6, 8'h02, 8'h00);
    chk_win(7, 8'h02, 8'h01);
    chk_win(8, 8'h02, 8'h02);
    $display("scan P=5 pad=0: windows=%0d handshakes=%0d", nwin, hs);

    // Backpressure on every handshake plus an ignored start and config change mid-scan
    run_scan(4, 0, 5, 3, 20, 1'b0, 1'b1, 32);
    chk_win(0, 8'h00, 8'h00);
    chk_win(3, 8'h00, 8'h01);
    $display("scan P=4 backpressure: windows=%0d handshakes=%0d", nwin, hs);

    // Degenerate picture: no windows, done right after start
    run_scan(2, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    $display("scan P=2 pad=0: windows=%0d handshakes=%0d", nwin, hs);

    // Reset while a window is presented to the OPU
    bus.start = 1'b1; bus.pic_size = 8'd4; bus.padding = 1'b0;
    @(negedge sys_clk);
    bus.start = 1'b0;
    bus.fetch_rdy = 1'b1;
    n = 0;
    while (bus.opu_vld !== 1'b1 && n < 50) begin
      bus.load_done = ~bus.fetch_vld;
      @(negedge sys_clk);
      n++;
    end
    bus.fetch_rdy = 1'b0; bus.load_done = 1'b0;
    chk("reached_present", 32'(n < 50), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst_opu_vld", 32'(bus.opu_vld), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_fetch_vld", 32'(bus.fetch_vld), 32'd0);
    chk("midrst_win_bit", 32'(bus.win_bit), 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    bus.opu_rdy = 1'b1;
    repeat (3) @(negedge sys_clk);
    bus.opu_rdy = 1'b0;
    chk("postrst_opu_vld", 32'(bus.opu_vld), 32'd0);
    chk("postrst_busy", 32'(bus.busy), 32'd0);
    $display("reset during PRESENT: opu_vld=%0b busy=%0b", bus.opu_vld, bus.busy);

    run_scan(4, 1, 0, 0, 0, 1'b0, 1'b0, 128);
    chk_win(0, 8'hFF, 8'hFF);
    chk_win(4, 8'hFF, 8'h01);
    chk_win(8, 8'h01, 8'hFF);
    $display("scan after reset P=4 pad=1: windows=%0d handshakes=%0d", nwin, hs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
